// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder
// Purpose  : Encodes LD/ADD/STO ops, queues them and issues each one as a
//            packed value/enable word for the ctrl decoder.
// Option   : INSTR_ENC_ILLEGAL_CHK_EN - drop op_code=3 and flag it on ill_err.
// Revision : 1.0 - initial release
// ============================================================================
module instr_encoder #(
  parameter int ADDRESS_BITS = 5,
  parameter int INSTR_BITS   = 3,
  parameter int DEPTH        = 4,
  parameter int HOLD_CYCLES  = 2,
  parameter int GAP_CYCLES   = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 op_valid,
  output logic                                 op_ready,
  input  logic [1:0]                           op_code,
  input  logic [ADDRESS_BITS-1:0]              op_addr,
  output logic [INSTR_BITS+ADDRESS_BITS-1:0]   value,
  output logic                                 enable,
  output logic                                 busy,
  output logic [7:0]                           issued_cnt
`ifdef INSTR_ENC_ILLEGAL_CHK_EN
  ,
  output logic                                 ill_err
`endif
);

  localparam int VALUE_BITS = INSTR_BITS + ADDRESS_BITS;
  localparam int PTR_W      = $clog2(DEPTH);
  localparam int MAX_CYC    = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  // The counter only ever holds MAX_CYC-1 down to 0.
  localparam int CNT_W      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  logic [VALUE_BITS-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W:0]        count;
  logic                  accept;
  logic                  push;
  logic                  pop;
  logic [INSTR_BITS-1:0] opc;
  logic [VALUE_BITS-1:0] enc_word;

  state_t                state;
  state_t                state_n;
  logic [CNT_W-1:0]      cyc_cnt;
  logic [CNT_W-1:0]      cyc_cnt_n;
  logic                  enable_n;
  logic [VALUE_BITS-1:0] value_n;
  logic                  issue_done;

  // One-hot opcode; op_code=3 maps to all-zero, the decoder's illegal case.
  always_comb begin
    opc = '0;
    case (op_code)
      2'd0:    opc = INSTR_BITS'(1);
      2'd1:    opc = INSTR_BITS'(2);
      2'd2:    opc = INSTR_BITS'(4);
      default: opc = '0;
    endcase
  end

  assign enc_word = {opc, op_addr};
  assign op_ready = (count != FULL_COUNT);
  assign accept   = op_valid && op_ready;

`ifdef INSTR_ENC_ILLEGAL_CHK_EN
  logic is_illegal;
  assign is_illegal = (op_code == 2'd3);
  assign push       = accept && !is_illegal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ill_err <= 1'b0;
    end else if (accept && is_illegal) begin
      ill_err <= 1'b1;
    end
  end
`else
  assign push = accept;
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= enc_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cyc_cnt    <= '0;
      enable     <= 1'b0;
      value      <= '0;
      issued_cnt <= 8'd0;
    end else begin
      state   <= state_n;
      cyc_cnt <= cyc_cnt_n;
      enable  <= enable_n;
      value   <= value_n;
      if (issue_done) begin
        issued_cnt <= issued_cnt + 8'd1;
      end
    end
  end

  // value is only reloaded on a pop, so it holds through HOLD and GAP.
  always_comb begin
    state_n    = state;
    cyc_cnt_n  = cyc_cnt;
    enable_n   = enable;
    value_n    = value;
    pop        = 1'b0;
    issue_done = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop       = 1'b1;
          value_n   = mem[rd_ptr];
          enable_n  = 1'b1;
          cyc_cnt_n = HOLD_LOAD;
          state_n   = HOLD;
        end
      end
      HOLD: begin
        if (cyc_cnt == '0) begin
          enable_n   = 1'b0;
          cyc_cnt_n  = GAP_LOAD;
          issue_done = 1'b1;
          state_n    = GAP;
        end else begin
          cyc_cnt_n = cyc_cnt - 1'b1;
        end
      end
      GAP: begin
        if (cyc_cnt == '0) begin
          state_n = IDLE;
        end else begin
          cyc_cnt_n = cyc_cnt - 1'b1;
        end
      end
      default: begin
        enable_n = 1'b0;
        state_n  = IDLE;
      end
    endcase
  end

  assign busy = (count != '0) || (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// Directed self-checking bench for instr_encoder (default parameters).
module tb_instr_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       op_valid = 1'b0;
  logic       op_ready;
  logic [1:0] op_code = 2'd0;
  logic [4:0] op_addr = 5'd0;
  logic [7:0] value;
  logic       enable;
  logic       busy;
  logic [7:0] issued_cnt;
`ifdef INSTR_ENC_ILLEGAL_CHK_EN
  logic       ill_err;
`endif

  int passed = 0;
  int total  = 0;

  instr_encoder dut (
    .clk        (clk),
    .rst        (rst),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_code    (op_code),
    .op_addr    (op_addr),
    .value      (value),
    .enable     (enable),
    .busy       (busy),
    .issued_cnt (issued_cnt)
`ifdef INSTR_ENC_ILLEGAL_CHK_EN
    ,
    .ill_err    (ill_err)
`endif
  );

  always #5 clk = ~clk;

  // Monitor of the issue strobe, sampled on the falling edge.
  int         cyc = 0;
  logic       prev_en = 1'b0;
  logic [7:0] hold_val = 8'd0;
  int         hi_len = 0;
  int         unstable = 0;
  logic [7:0] rise_vals[$];
  int         rise_cyc[$];
  int         hi_lens[$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      prev_en <= 1'b0;
      hi_len  <= 0;
    end else begin
      prev_en <= enable;
      if (enable && !prev_en) begin
        rise_vals.push_back(value);
        rise_cyc.push_back(cyc);
        hold_val <= value;
        hi_len   <= 1;
      end else if (enable) begin
        hi_len <= hi_len + 1;
        if (value !== hold_val) unstable <= unstable + 1;
      end else if (prev_en) begin
        hi_lens.push_back(hi_len);
      end
    end
  end

  function automatic logic [7:0] enc(input logic [1:0] c, input logic [4:0] a);
    case (c)
      2'd0:    return {3'b001, a};
      2'd1:    return {3'b010, a};
      2'd2:    return {3'b100, a};
      default: return {3'b000, a};
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    op_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic push_op(input logic [1:0] c, input logic [4:0] a);
    int t;
    op_code  = c;
    op_addr  = a;
    op_valid = 1'b1;
    for (t = 0; t < 50 && !op_ready; t++) step();
    total++;
    if (op_ready !== 1'b1) $display("FAIL push_ready: op_ready=%b required 1", op_ready);
    else passed++;
    step();
    op_valid = 1'b0;
  endtask

  task automatic wait_falls(input int n, input int budget);
    int t;
    for (t = 0; t < budget && hi_lens.size() < n; t++) step();
    total++;
    if (hi_lens.size() < n) $display("FAIL wait_issue: words seen %0d required %0d", hi_lens.size(), n);
    else passed++;
  endtask

  task automatic test_reset();
    do_reset();
    total += 5;
    if (value !== 8'h00) $display("FAIL rst_value: got %h required 00", value); else passed++;
    if (enable !== 1'b0) $display("FAIL rst_enable: got %b required 0", enable); else passed++;
    if (busy !== 1'b0) $display("FAIL rst_busy: got %b required 0", busy); else passed++;
    if (issued_cnt !== 8'd0) $display("FAIL rst_issued: got %0d required 0", issued_cnt); else passed++;
    if (op_ready !== 1'b1) $display("FAIL rst_ready: got %b required 1", op_ready); else passed++;
  endtask

  task automatic test_single();
    int rb = rise_vals.size();
    int hb = hi_lens.size();
    push_op(2'd0, 5'h0A);
    total++;
    if (busy !== 1'b1) $display("FAIL single_busy: got %b required 1", busy); else passed++;
    wait_falls(hb + 1, 20);
    total += 5;
    if (rise_vals.size() <= rb || rise_vals[rb] !== 8'h2A)
      $display("FAIL single_value: got %h required 2a", (rise_vals.size() > rb) ? rise_vals[rb] : 8'hxx);
    else passed++;
    if (hi_lens.size() <= hb || hi_lens[hb] != 2)
      $display("FAIL single_hold: got %0d required 2", (hi_lens.size() > hb) ? hi_lens[hb] : -1);
    else passed++;
    if (enable !== 1'b0) $display("FAIL single_gap: enable=%b required 0", enable); else passed++;
    if (issued_cnt !== 8'd1) $display("FAIL single_cnt: got %0d required 1", issued_cnt); else passed++;
    step();
    if (busy !== 1'b0) $display("FAIL single_idle: busy=%b required 0", busy); else passed++;
  endtask

  // Five ops with op_valid held high; the first is popped one edge after its
  // push, so the FIFO is full (op_ready low) right after the fifth accept.
  task automatic drive_burst();
    int acc = 0;
    int t;
    op_valid = 1'b1;
    for (t = 0; t < 40 && acc < 5; t++) begin
      logic rdy;
      op_code = 2'(acc % 3);
      op_addr = 5'(acc + 1);
      rdy = op_ready;
      step();
      if (rdy) acc++;
    end
    op_valid = 1'b0;
    total++;
    if (acc != 5) $display("FAIL burst_accepts: got %0d required 5", acc); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_w [5] = '{8'h21, 8'h42, 8'h83, 8'h24, 8'h45};
    int rb, hb;
    do_reset();
    rb = rise_vals.size();
    hb = hi_lens.size();
    drive_burst();
    total++;
    if (op_ready !== 1'b0) $display("FAIL burst_full: op_ready=%b required 0", op_ready); else passed++;
    wait_falls(hb + 5, 60);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (rise_vals.size() <= rb + i || rise_vals[rb + i] !== exp_w[i])
        $display("FAIL burst_word%0d: got %h required %h", i,
                 (rise_vals.size() > rb + i) ? rise_vals[rb + i] : 8'hxx, exp_w[i]);
      else passed++;
      total++;
      if (hi_lens.size() <= hb + i || hi_lens[hb + i] != 2)
        $display("FAIL burst_hold%0d: got %0d required 2", i,
                 (hi_lens.size() > hb + i) ? hi_lens[hb + i] : -1);
      else passed++;
    end
    for (int i = 1; i < 5; i++) begin
      total++;
      if (rise_cyc.size() <= rb + i || rise_cyc[rb + i] - rise_cyc[rb + i - 1] != 4)
        $display("FAIL burst_period%0d: got %0d required 4", i,
                 (rise_cyc.size() > rb + i) ? rise_cyc[rb + i] - rise_cyc[rb + i - 1] : -1);
      else passed++;
    end
    total++;
    if (issued_cnt !== 8'd5) $display("FAIL burst_cnt: got %0d required 5", issued_cnt); else passed++;
  endtask

  task automatic test_sto_add();
    int rb = rise_vals.size();
    int hb = hi_lens.size();
    int ub = unstable;
    push_op(2'd2, 5'h1F);
    push_op(2'd1, 5'h00);
    wait_falls(hb + 2, 30);
    total += 3;
    if (rise_vals.size() <= rb || rise_vals[rb] !== 8'h9F)
      $display("FAIL sto_value: got %h required 9f", (rise_vals.size() > rb) ? rise_vals[rb] : 8'hxx);
    else passed++;
    if (rise_vals.size() <= rb + 1 || rise_vals[rb + 1] !== 8'h40)
      $display("FAIL add_value: got %h required 40", (rise_vals.size() > rb + 1) ? rise_vals[rb + 1] : 8'hxx);
    else passed++;
    if (unstable != ub) $display("FAIL value_stable: changes while enabled %0d required 0", unstable - ub);
    else passed++;
  endtask

  task automatic test_illegal();
    int rb = rise_vals.size();
    int hb = hi_lens.size();
    logic [7:0] c0 = issued_cnt;
`ifdef INSTR_ENC_ILLEGAL_CHK_EN
    total++;
    if (ill_err !== 1'b0) $display("FAIL ill_err_pre: got %b required 0", ill_err); else passed++;
    push_op(2'd3, 5'h07);
    for (int i = 0; i < 10; i++) step();
    total += 3;
    if (rise_vals.size() != rb) $display("FAIL ill_no_issue: pulses %0d required 0", rise_vals.size() - rb);
    else passed++;
    if (ill_err !== 1'b1) $display("FAIL ill_err: got %b required 1", ill_err); else passed++;
    if (issued_cnt !== c0) $display("FAIL ill_cnt: got %0d required %0d", issued_cnt, c0); else passed++;
`else
    push_op(2'd3, 5'h07);
    wait_falls(hb + 1, 20);
    total += 2;
    if (rise_vals.size() <= rb || rise_vals[rb] !== 8'h07)
      $display("FAIL ill_value: got %h required 07", (rise_vals.size() > rb) ? rise_vals[rb] : 8'hxx);
    else passed++;
    if (issued_cnt !== c0 + 8'd1) $display("FAIL ill_cnt: got %0d required %0d", issued_cnt, c0 + 8'd1);
    else passed++;
`endif
  endtask

  task automatic test_reset_mid_hold();
    int rb;
    do_reset();
    drive_burst();
    step();
    // Second word is now in HOLD with three words still queued.
    total++;
    if (enable !== 1'b1) $display("FAIL mid_pre_enable: got %b required 1", enable); else passed++;
    rst = 1'b1;
    #1;
    total += 5;
    if (enable !== 1'b0) $display("FAIL mid_enable: got %b required 0", enable); else passed++;
    if (busy !== 1'b0) $display("FAIL mid_busy: got %b required 0", busy); else passed++;
    if (op_ready !== 1'b1) $display("FAIL mid_ready: got %b required 1", op_ready); else passed++;
    if (value !== 8'h00) $display("FAIL mid_value: got %h required 00", value); else passed++;
    if (issued_cnt !== 8'd0) $display("FAIL mid_cnt: got %0d required 0", issued_cnt); else passed++;
    step();
    rst = 1'b0;
    rb = rise_vals.size();
    for (int i = 0; i < 12; i++) step();
    total += 2;
    if (rise_vals.size() != rb) $display("FAIL mid_no_issue: pulses %0d required 0", rise_vals.size() - rb);
    else passed++;
    if (busy !== 1'b0) $display("FAIL mid_busy_after: got %b required 0", busy); else passed++;
  endtask

  task automatic test_wrap();
    logic [7:0] expq[$];
    int rb, hb;
    do_reset();
    rb = rise_vals.size();
    hb = hi_lens.size();
    for (int i = 0; i < 256; i++) begin
      logic [1:0] c = 2'(i % 3);
      logic [4:0] a = 5'((i * 7 + 3) % 32);
      expq.push_back(enc(c, a));
      push_op(c, a);
    end
    wait_falls(hb + 256, 200);
    for (int i = 0; i < 256; i++) begin
      total++;
      if (rise_vals.size() <= rb + i || rise_vals[rb + i] !== expq[i])
        $display("FAIL wrap_word%0d: got %h required %h", i,
                 (rise_vals.size() > rb + i) ? rise_vals[rb + i] : 8'hxx, expq[i]);
      else passed++;
    end
    step();
    total += 3;
    if (rise_vals.size() != rb + 256) $display("FAIL wrap_count: words %0d required 256", rise_vals.size() - rb);
    else passed++;
    if (issued_cnt !== 8'd0) $display("FAIL wrap_cnt: got %0d required 0", issued_cnt); else passed++;
    if (busy !== 1'b0) $display("FAIL wrap_busy: got %b required 0", busy); else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_sto_add();
    test_illegal();
    test_reset_mid_hold();
    test_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d", passed, total);
    $fatal(1);
  end

endmodule
`default_nettype wire
